// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-port SDRAM arbiter: FSM encoding,
// default parameter values and the timeout counter width.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_W      = 22;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_TIMEOUT_CYC = 1023;

    // Wide enough for the largest legal timeout (65535 cycles).
    localparam int CNT_W = 16;

    // One-hot grant vector for a port index.
    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sdram_arb_rr.sv
// Two-way round-robin pick. A lone requester always wins; on a tie the
// port that did not win last time is chosen. The pointer resets to port 1
// so that port 0 takes the first tie after reset.
module sdram_arb_rr
    import sdram_arb_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       winner,
    output logic [1:0] pick
);

    logic last;

    // Remember the most recent winner when the top level commits a grant
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last <= 1'b1;
        end else if (upd) begin
            last <= winner;
        end
    end

    // Combinational pick from the current requests and the pointer
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = port_onehot(~last);
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port round-robin front end for the SDRAM controller. Each request is
// a single-word read or write; the granted command is latched, held on the
// controller's level-sensitive enable until Done (or a timeout abort), and
// completion plus read data is returned to the granted port.
// TIMEOUT_CYC legal range: 4..65535.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              P0_Req_Sig,
    input  logic              P1_Req_Sig,
    input  logic              P0_Wr_Sig,
    input  logic              P1_Wr_Sig,
    input  logic [ADDR_W-1:0] P0_Addr,
    input  logic [ADDR_W-1:0] P1_Addr,
    input  logic [DATA_W-1:0] P0_WrData,
    input  logic [DATA_W-1:0] P1_WrData,
    output logic              P0_Done_Sig,
    output logic              P1_Done_Sig,
    output logic              P0_Err_Sig,
    output logic              P1_Err_Sig,
    output logic [DATA_W-1:0] RdData,
    output logic [1:0]        Gnt,
    output logic              Busy_Sig,
    output logic              WrEN_Sig,
    output logic              RdEN_Sig,
    output logic [ADDR_W-1:0] BRC_Addr,
    output logic [DATA_W-1:0] WrData,
    input  logic              C_Done_Sig,
    input  logic [DATA_W-1:0] C_RdData
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e        state;
    arb_state_e        state_d;
    logic [1:0]        req;
    logic [1:0]        pick;
    logic              take;
    logic              finish;
    logic              time_out;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [CNT_W-1:0]  cnt;

    assign req      = {P1_Req_Sig, P0_Req_Sig};
    assign sel_wr   = pick[1] ? P1_Wr_Sig : P0_Wr_Sig;
    assign sel_addr = pick[1] ? P1_Addr   : P0_Addr;
    assign sel_data = pick[1] ? P1_WrData : P0_WrData;

    // The pointer moves to the granted port as the transaction enters ACK
    sdram_arb_rr u_rr (
        .CLK    (CLK),
        .RST    (RST),
        .req    (req),
        .upd    (finish),
        .winner (Gnt[1]),
        .pick   (pick)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and the transition strobes that drive the registers below;
    // a controller Done on the last timeout cycle takes priority over abort
    always_comb begin
        state_d  = state;
        take     = 1'b0;
        finish   = 1'b0;
        time_out = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick != 2'b00) begin
                    state_d = ST_ISSUE;
                    take    = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (C_Done_Sig) begin
                    state_d = ST_ACK;
                    finish  = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_d  = ST_ACK;
                    finish   = 1'b1;
                    time_out = 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Command registers latch the winner's address/data; the timeout counter
    // restarts on each grant and counts ISSUE cycles without a Done
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt      <= '0;
            BRC_Addr <= '0;
            WrData   <= '0;
        end else if (take) begin
            cnt      <= '0;
            BRC_Addr <= sel_addr;
            WrData   <= sel_data;
        end else if (state == ST_ISSUE && !finish) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Registered port-side and controller-side outputs, updated on the
    // grant, completion and ACK-exit transitions
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Gnt         <= 2'b00;
            Busy_Sig    <= 1'b0;
            WrEN_Sig    <= 1'b0;
            RdEN_Sig    <= 1'b0;
            P0_Done_Sig <= 1'b0;
            P1_Done_Sig <= 1'b0;
            P0_Err_Sig  <= 1'b0;
            P1_Err_Sig  <= 1'b0;
            RdData      <= '0;
        end else begin
            if (take) begin
                Gnt      <= pick;
                Busy_Sig <= 1'b1;
                WrEN_Sig <= sel_wr;
                RdEN_Sig <= ~sel_wr;
            end
            if (finish) begin
                WrEN_Sig    <= 1'b0;
                RdEN_Sig    <= 1'b0;
                P0_Done_Sig <= Gnt[0];
                P1_Done_Sig <= Gnt[1];
                P0_Err_Sig  <= Gnt[0] & time_out;
                P1_Err_Sig  <= Gnt[1] & time_out;
                RdData      <= time_out ? '0 : C_RdData;
            end
            if (state == ST_ACK) begin
                Gnt         <= 2'b00;
                Busy_Sig    <= 1'b0;
                P0_Done_Sig <= 1'b0;
                P1_Done_Sig <= 1'b0;
                P0_Err_Sig  <= 1'b0;
                P1_Err_Sig  <= 1'b0;
            end
        end
    end

endmodule
